// File: rtl/dmem_loader_pkg.sv
// dmem_loader_pkg: shared state encoding and byte-lane constants for the data-memory loader
package dmem_loader_pkg;
  typedef enum logic [2:0] {
    IDLE,
    L_COLLECT,
    L_WRITE,
    D_READ,
    D_WAIT,
    D_SEND,
    FINISH
  } st_e;
  localparam logic [2:0] FUNCT3_SW = 3'b010;
  localparam int LANE_W = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int PK_CNT_W = 3;
endpackage

// File: rtl/dmem_loader_byte_word_packer.sv
// byte_word_packer: assembles four bytes little-endian into a word, with a fill count and full flag
module byte_word_packer
  import dmem_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                push,
  input  logic [LANE_W-1:0]   din,
  output logic [31:0]         word,
  output logic [PK_CNT_W-1:0] cnt,
  output logic                full
);
  assign full = cnt == PK_CNT_W'(BYTES_PER_WORD);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (push) begin
      word <= {din, word[31:LANE_W]};
      cnt  <= cnt + PK_CNT_W'(1);
    end
endmodule

// File: rtl/dmem_loader.sv
// dmem_loader: streams host bytes into data memory as word pairs, or dumps memory words as bytes
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic              abort,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic [31:0]       mem_wd2,
  output logic [2:0]        mem_funct3,
  output logic              mem_enable_half,
  output logic              mem_enable_load,
  input  logic [31:0]       mem_rd,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [31:0] MAX_W = 32'(1) << (ADDR_W - 2);
  st_e state, nxt;
  logic [LEN_W-1:0]    left_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wd_q, wd2_q, sh_q, out_word, lo_word, hi_word;
  logic [1:0]          bcnt_q;
  logic                fresh_q, err_q;
  logic [PK_CNT_W-1:0] lo_cnt, hi_cnt;
  logic                lo_full, hi_full, start, accept, too_long, tail, push, last_byte, hs;
  assign start     = start_load | start_dump;
  assign accept    = state == IDLE && start && !abort;
  assign too_long  = 32'(len_words) > MAX_W;
  assign tail      = left_q == LEN_W'(1);
  assign in_ready  = state == L_COLLECT && !(hi_full || (tail && lo_full));
  assign push      = in_valid && in_ready;
  assign last_byte = push && (tail ? lo_cnt == PK_CNT_W'(3) : hi_cnt == PK_CNT_W'(3));
  assign hs        = out_valid && out_ready;
  // the first send cycle forwards mem_rd directly so the byte stream starts RD_LAT cycles after the read
  assign out_word  = fresh_q ? mem_rd : sh_q;
  byte_word_packer u_lo (
    .clk (clk),
    .rst (rst),
    .clr (state != L_COLLECT),
    .push(push && !lo_full),
    .din (in_data),
    .word(lo_word),
    .cnt (lo_cnt),
    .full(lo_full)
  );
  byte_word_packer u_hi (
    .clk (clk),
    .rst (rst),
    .clr (state != L_COLLECT),
    .push(push && lo_full),
    .din (in_data),
    .word(hi_word),
    .cnt (hi_cnt),
    .full(hi_full)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (start) nxt = (too_long || len_words == '0) ? FINISH : start_load ? L_COLLECT : D_READ;
      L_COLLECT: if (last_byte) nxt = L_WRITE;
      L_WRITE:   nxt = left_q > LEN_W'(2) ? L_COLLECT : FINISH;
      D_READ:    nxt = RD_LAT > 1 ? D_WAIT : D_SEND;
      D_WAIT:    nxt = D_SEND;
      D_SEND:    if (hs && bcnt_q == 2'd3) nxt = left_q > LEN_W'(1) ? D_READ : FINISH;
      FINISH:    nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      left_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      wd2_q   <= '0;
      sh_q    <= '0;
      bcnt_q  <= '0;
      fresh_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= nxt;
      fresh_q <= nxt == D_SEND && state != D_SEND;
      if (accept) begin
        left_q <= len_words;
        addr_q <= '0;
        bcnt_q <= '0;
        err_q  <= too_long;
      end
      if (state == L_WRITE) begin
        wd_q   <= lo_word;
        if (!tail) wd2_q <= hi_word;
        left_q <= tail ? '0 : left_q - LEN_W'(2);
        addr_q <= addr_q + ADDR_W'(8);
      end
      if (hs) begin
        sh_q   <= out_word >> 8;
        bcnt_q <= bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          left_q <= left_q - LEN_W'(1);
          addr_q <= addr_q + ADDR_W'(4);
        end
      end else if (fresh_q) begin
        sh_q <= mem_rd;
      end
    end
  assign mem_write       = state == L_WRITE;
  assign mem_enable_load = state == L_WRITE;
  assign mem_enable_half = state == L_WRITE && tail;
  assign mem_read        = state == D_READ;
  assign mem_funct3      = (mem_write || mem_read) ? FUNCT3_SW : 3'b000;
  assign mem_addr        = addr_q;
  assign mem_wd          = mem_write ? lo_word : wd_q;
  assign mem_wd2         = (mem_write && !tail) ? hi_word : wd2_q;
  assign out_valid       = state == D_SEND;
  assign out_data        = out_word[7:0];
  assign busy            = state != IDLE && state != FINISH;
  assign done            = state == FINISH && !abort;
  assign err             = err_q;
endmodule

// File: tb/tb_dmem_loader.sv
// tb_dmem_loader: scoreboard bench; stimulus queues expected writes/bytes, a monitor pops and compares
module tb_dmem_loader;
  localparam int ADDR_W = 9;
  localparam int LEN_W = 8;
  logic clk = 1'b0;
  logic rst, start_load, start_dump, abort, in_valid, in_ready, out_valid, out_ready;
  logic mem_write, mem_read, mem_enable_half, mem_enable_load, busy, done, err;
  logic [LEN_W-1:0] len_words;
  logic [7:0] in_data, out_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wd, mem_wd2;
  logic [31:0] mem_rd = '0;
  logic [2:0] mem_funct3;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0] wd;
    logic [31:0] wd2;
    logic half;
  } wr_t;
  wr_t exp_wr[$];
  logic [7:0] exp_out[$];
  wr_t e;
  int nvec = 0, nerr = 0, nwr = 0, nrd = 0, ndone = 0;
  logic [31:0] mem[0:127];
  logic stall_q = 1'b0;
  logic [7:0] held;
  always #5 clk = ~clk;
  dmem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .start_dump(start_dump), .abort(abort),
    .len_words(len_words), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_wd2(mem_wd2), .mem_funct3(mem_funct3), .mem_enable_half(mem_enable_half),
    .mem_enable_load(mem_enable_load), .mem_rd(mem_rd), .busy(busy), .done(done), .err(err)
  );
  always @(posedge clk) if (mem_read) mem_rd <= mem[mem_addr[ADDR_W-1:2]];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) stall_q = 1'b0;
    else begin
      if (stall_q) chk("out_hold", {out_valid, out_data}, {1'b1, held});
      stall_q = out_valid && !out_ready;
      held = out_data;
      if (mem_read) nrd++;
      if (done) ndone++;
      if (mem_write) begin
        nwr++;
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_wd", mem_wd, e.wd);
          if (!e.half) chk("wr_wd2", mem_wd2, e.wd2);
          chk("wr_half", mem_enable_half, e.half);
          chk("wr_ctl", {mem_enable_load, mem_funct3}, {1'b1, 3'b010});
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk("out_unexpected", 1, 0);
        else chk("out_byte", out_data, exp_out.pop_front());
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(input logic ld, input logic dp, input logic [LEN_W-1:0] n);
    start_load = ld;
    start_dump = dp;
    len_words = n;
    tick;
    start_load = 1'b0;
    start_dump = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    repeat (gap) tick;
    in_valid = 1'b1;
    in_data = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      tick;
    end
    in_valid = 1'b0;
    if (!ok) chk("in_ready_timeout", 0, 1);
  endtask
  task automatic wait_done(output int lat);
    lat = -1;
    for (int t = 1; t <= 300 && lat < 0; t++) begin
      @(negedge clk);
      if (done) lat = t;
    end
    if (lat < 0) chk("done_timeout", 0, 1);
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, w0, r0, d0;
    rst = 1'b1; start_load = 0; start_dump = 0; abort = 0; len_words = '0;
    in_valid = 0; in_data = '0; out_ready = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'(i) * 32'h01010101;
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h12345678;
    repeat (2) tick;
    chk("reset_outputs", {busy, done, err, out_valid, out_data, mem_write, mem_read, mem_addr,
                          mem_enable_half, mem_enable_load, in_ready}, 0);
    chk("reset_wd", {mem_wd, mem_wd2}, 0);
    rst = 1'b0;
    tick;
    // load 4 words, no stalls
    w0 = nwr; d0 = ndone;
    exp_wr.push_back('{addr: 9'd0, wd: 32'h03020100, wd2: 32'h07060504, half: 1'b0});
    exp_wr.push_back('{addr: 9'd8, wd: 32'h0B0A0908, wd2: 32'h0F0E0D0C, half: 1'b0});
    pulse_start(1, 0, 4);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
    wait_done(lat);
    chk("l4_writes", nwr - w0, 2);
    chk("l4_done", ndone - d0, 1);
    chk("l4_queue", exp_wr.size(), 0);
    chk("l4_hold_wd", {mem_wd, mem_wd2, mem_write}, {32'h0B0A0908, 32'h0F0E0D0C, 1'b0});
    // load 3 words, gapped input, odd tail
    w0 = nwr; d0 = ndone;
    exp_wr.push_back('{addr: 9'd0, wd: 32'h13121110, wd2: 32'h17161514, half: 1'b0});
    exp_wr.push_back('{addr: 9'd8, wd: 32'h1B1A1918, wd2: 32'h0, half: 1'b1});
    pulse_start(1, 0, 3);
    for (int i = 0; i < 12; i++) send_byte(8'(8'h10 + i), i % 2 + 1);
    wait_done(lat);
    chk("l3_writes", nwr - w0, 2);
    chk("l3_done", ndone - d0, 1);
    chk("l3_queue", exp_wr.size(), 0);
    // dump 2 words with out_ready toggling
    r0 = nrd; d0 = ndone; w0 = nwr;
    foreach (exp_out[i]) exp_out.delete(i);
    exp_out.push_back(8'hEF); exp_out.push_back(8'hBE); exp_out.push_back(8'hAD); exp_out.push_back(8'hDE);
    exp_out.push_back(8'h78); exp_out.push_back(8'h56); exp_out.push_back(8'h34); exp_out.push_back(8'h12);
    pulse_start(0, 1, 2);
    fork
      for (int t = 0; t < 60; t++) begin
        out_ready = (t % 2) != 0;
        tick;
      end
      wait_done(lat);
    join
    out_ready = 1'b0;
    chk("d2_reads", nrd - r0, 2);
    chk("d2_done", ndone - d0, 1);
    chk("d2_queue", exp_out.size(), 0);
    chk("d2_no_write", nwr - w0, 0);
    // length overflow
    r0 = nrd; d0 = ndone; w0 = nwr;
    pulse_start(1, 0, 200);
    wait_done(lat);
    chk("len_err", err, 1);
    chk("len_done", ndone - d0, 1);
    chk("len_no_access", (nwr - w0) + (nrd - r0), 0);
    repeat (3) tick;
    chk("len_err_sticky", err, 1);
    // zero length with both starts
    r0 = nrd; d0 = ndone; w0 = nwr;
    start_load = 1'b1; start_dump = 1'b1; len_words = '0;
    @(negedge clk);
    chk("zero_done_early", done, 0);
    tick;
    start_load = 1'b0; start_dump = 1'b0;
    @(negedge clk);
    chk("zero_done_2cyc", {done, busy}, 2'b10);
    @(negedge clk);
    chk("zero_done_single", done, 0);
    chk("zero_err_clear", err, 0);
    chk("zero_no_access", (nwr - w0) + (nrd - r0) + (ndone - d0), 1);
    tick;
    // abort after 5 bytes of a load
    w0 = nwr; d0 = ndone;
    pulse_start(1, 0, 4);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    repeat (5) tick;
    chk("abort_no_write", nwr - w0, 0);
    chk("abort_no_done", ndone - d0, 0);
    w0 = nwr; d0 = ndone;
    exp_wr.push_back('{addr: 9'd0, wd: 32'h23222120, wd2: 32'h27262524, half: 1'b0});
    pulse_start(1, 0, 2);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h20 + i), 0);
    wait_done(lat);
    chk("post_abort_write", nwr - w0, 1);
    chk("post_abort_done", ndone - d0, 1);
    // reset mid-dump
    pulse_start(0, 1, 2);
    repeat (3) tick;
    #2 rst = 1'b1;
    #1;
    chk("rst_outputs", {busy, done, err, out_valid, out_data, mem_write, mem_read, mem_addr,
                        mem_enable_half, mem_enable_load, in_ready}, 0);
    chk("rst_wd", {mem_wd, mem_wd2}, 0);
    tick;
    rst = 1'b0;
    tick;
    d0 = ndone; r0 = nrd;
    exp_out.push_back(8'hEF); exp_out.push_back(8'hBE); exp_out.push_back(8'hAD); exp_out.push_back(8'hDE);
    out_ready = 1'b1;
    pulse_start(0, 1, 1);
    wait_done(lat);
    chk("post_rst_done", ndone - d0, 1);
    chk("post_rst_reads", nrd - r0, 1);
    chk("post_rst_queue", exp_out.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
